// File: rtl/l2_sio_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_sio_chk_pkg
// Purpose  : Shared types and the parity helper for the L2-to-SIO read-response
//            checker.
// Revision : 1.0 - initial release
// ============================================================================
package l2_sio_chk_pkg;

  // Widest data beat and parity field the helper can handle.
  localparam int c_max_data_w = 64;
  localparam int c_max_par_w  = 8;

  typedef enum logic [1:0] {
    ERR_PARITY   = 2'd0,
    ERR_UE       = 2'd1,
    ERR_OVERLAP  = 2'd2,
    ERR_STRAY_UE = 2'd3
  } err_code_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DATA = 1'b1
  } bank_state_t;

  // Even parity per segment: bit k covers data[k*seg_w +: seg_w]. Callers
  // zero-extend the data and use the low par_w bits of the result.
  function automatic logic [c_max_par_w-1:0] even_par(
    input logic [c_max_data_w-1:0] data,
    input int                      seg_w,
    input int                      par_w
  );
    logic [c_max_par_w-1:0] p;
    p = '0;
    for (int k = 0; k < c_max_par_w; k++) begin
      for (int j = 0; j < c_max_data_w; j++) begin
        if ((k < par_w) && (j >= k * seg_w) && (j < (k + 1) * seg_w)) begin
          p[k] = p[k] ^ data[j];
        end
      end
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/l2_sio_bank_chk.sv
`default_nettype none
// ============================================================================
// Module   : l2_sio_bank_chk
// Purpose  : One bank's packet-framing FSM, beat parity check, saturating
//            packet/UE counters and sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module l2_sio_bank_chk #(
  parameter int DATA_W    = 32,
  parameter int PAR_W     = 2,
  parameter int PKT_BEATS = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mon_en,
  input  logic              i_clr_cnt,
  input  logic              i_ctag_vld,
  input  logic [DATA_W-1:0] i_data,
  input  logic [PAR_W-1:0]  i_parity,
  input  logic              i_ue_err,
  output logic              o_pkt_done,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic              o_err_sticky,
  output logic [CNT_W-1:0]  o_ue_cnt,
  output logic [CNT_W-1:0]  o_pkt_cnt
);
  import l2_sio_chk_pkg::*;

  localparam int                  c_seg_w     = DATA_W / PAR_W;
  localparam int                  c_beat_w    = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(PKT_BEATS - 1);
  localparam logic [CNT_W-1:0]    c_cnt_max   = '1;

  bank_state_t           r_state;
  logic [c_beat_w-1:0]   r_beat_cnt;
  logic                  r_pkt_done;
  logic                  r_err;
  err_code_t             r_err_code;
  logic                  r_err_sticky;
  logic [CNT_W-1:0]      r_ue_cnt;
  logic [CNT_W-1:0]      r_pkt_cnt;

  logic [c_max_data_w-1:0] w_data_ext;
  logic [c_max_par_w-1:0]  w_par_exp;
  logic                    w_beat;
  logic                    w_par_err;
  logic                    w_overlap;
  logic                    w_ue;
  logic                    w_stray;
  logic                    w_done;
  logic                    w_err;
  err_code_t               w_code;

  // Classify this cycle's beat and pick the highest-priority error.
  always_comb begin
    w_data_ext               = '0;
    w_data_ext[DATA_W-1:0]   = i_data;
    w_par_exp                = even_par(w_data_ext, c_seg_w, PAR_W);
    // A beat is the header (ctag_vld) or any cycle while a packet is open.
    w_beat    = i_mon_en && (i_ctag_vld || (r_state == DATA));
    w_par_err = w_beat && (w_par_exp[PAR_W-1:0] != i_parity);
    w_overlap = i_mon_en && (r_state == DATA) && i_ctag_vld;
    w_ue      = w_beat && i_ue_err;
    w_stray   = i_mon_en && (r_state == IDLE) && !i_ctag_vld && i_ue_err;
    // A new header on the last beat abandons the packet instead of closing it.
    w_done    = i_mon_en && (r_state == DATA) && !i_ctag_vld && (r_beat_cnt == c_last_beat);
    w_err     = w_overlap || w_ue || w_par_err || w_stray;
    if (w_overlap)      w_code = ERR_OVERLAP;
    else if (w_ue)      w_code = ERR_UE;
    else if (w_par_err) w_code = ERR_PARITY;
    else if (w_stray)   w_code = ERR_STRAY_UE;
    else                w_code = ERR_PARITY;
  end

  // Packet-framing FSM and beat counter; disable drops any open packet.
  always_ff @(posedge clk) begin
    if (rst || !i_mon_en) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
    end else if (i_ctag_vld) begin
      r_state    <= DATA;
      r_beat_cnt <= '0;
    end else if (r_state == DATA) begin
      if (r_beat_cnt == c_last_beat) begin
        r_state    <= IDLE;
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + c_beat_w'(1);
      end
    end
  end

  // Registered per-cycle event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_done <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_PARITY;
    end else begin
      r_pkt_done <= w_done;
      r_err      <= w_err;
      r_err_code <= w_code;
    end
  end

  // Sticky error: a new error beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)            r_err_sticky <= 1'b0;
    else if (w_err)     r_err_sticky <= 1'b1;
    else if (i_clr_cnt) r_err_sticky <= 1'b0;
  end

  // Saturating completed-packet counter; clear with increment loads 1.
  always_ff @(posedge clk) begin
    if (rst)                                r_pkt_cnt <= '0;
    else if (i_clr_cnt)                     r_pkt_cnt <= w_done ? CNT_W'(1) : '0;
    else if (w_done && r_pkt_cnt != c_cnt_max) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
  end

  // Saturating UE counter; counts UEs even when an overlap masks the code.
  always_ff @(posedge clk) begin
    if (rst)                             r_ue_cnt <= '0;
    else if (i_clr_cnt)                  r_ue_cnt <= w_ue ? CNT_W'(1) : '0;
    else if (w_ue && r_ue_cnt != c_cnt_max) r_ue_cnt <= r_ue_cnt + CNT_W'(1);
  end

  assign o_pkt_done   = r_pkt_done;
  assign o_err        = r_err;
  assign o_err_code   = r_err_code;
  assign o_err_sticky = r_err_sticky;
  assign o_ue_cnt     = r_ue_cnt;
  assign o_pkt_cnt    = r_pkt_cnt;

endmodule
`default_nettype wire

// File: rtl/l2_sio_resp_chk.sv
`default_nettype none
// ============================================================================
// Module   : l2_sio_resp_chk
// Purpose  : L2-bank-to-SIO read-response checker. One bank checker per L2
//            bank plus a lowest-index error report across banks.
// Revision : 1.0 - initial release
// ============================================================================
module l2_sio_resp_chk #(
  parameter int NUM_BANKS = 8,
  parameter int DATA_W    = 32,
  parameter int PAR_W     = 2,
  parameter int PKT_BEATS = 16,
  parameter int CNT_W     = 16,
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                        iol2clk,
  input  logic                        reset,
  input  logic                        mon_en,
  input  logic                        clr_cnt,
  input  logic [NUM_BANKS-1:0]        l2b_sio_ctag_vld,
  input  logic [NUM_BANKS*DATA_W-1:0] l2b_sio_data,
  input  logic [NUM_BANKS*PAR_W-1:0]  l2b_sio_parity,
  input  logic [NUM_BANKS-1:0]        l2b_sio_ue_err,
  output logic [NUM_BANKS-1:0]        pkt_done,
  output logic [NUM_BANKS-1:0]        err_vec,
  output logic                        err_vld,
  output logic [BANK_W-1:0]           err_bank,
  output logic [1:0]                  err_code,
  output logic [NUM_BANKS-1:0]        err_sticky,
  output logic [NUM_BANKS*CNT_W-1:0]  ue_cnt,
  output logic [NUM_BANKS*CNT_W-1:0]  pkt_cnt
);
  import l2_sio_chk_pkg::*;

  logic [1:0] w_bank_code [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    l2_sio_bank_chk #(
      .DATA_W    (DATA_W),
      .PAR_W     (PAR_W),
      .PKT_BEATS (PKT_BEATS),
      .CNT_W     (CNT_W)
    ) u_bank (
      .clk          (iol2clk),
      .rst          (reset),
      .i_mon_en     (mon_en),
      .i_clr_cnt    (clr_cnt),
      .i_ctag_vld   (l2b_sio_ctag_vld[b]),
      .i_data       (l2b_sio_data[b*DATA_W +: DATA_W]),
      .i_parity     (l2b_sio_parity[b*PAR_W +: PAR_W]),
      .i_ue_err     (l2b_sio_ue_err[b]),
      .o_pkt_done   (pkt_done[b]),
      .o_err        (err_vec[b]),
      .o_err_code   (w_bank_code[b]),
      .o_err_sticky (err_sticky[b]),
      .o_ue_cnt     (ue_cnt[b*CNT_W +: CNT_W]),
      .o_pkt_cnt    (pkt_cnt[b*CNT_W +: CNT_W])
    );
  end

  // Lowest-index flagged bank wins the shared bank/code report.
  always_comb begin
    err_vld  = |err_vec;
    err_bank = '0;
    err_code = 2'(ERR_PARITY);
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (err_vec[b]) begin
        err_bank = BANK_W'(b);
        err_code = w_bank_code[b];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_sio_resp_chk.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_sio_resp_chk
// Purpose  : Directed self-checking bench for l2_sio_resp_chk (CNT_W = 4 so
//            saturation is reachable quickly).
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_sio_resp_chk;

  localparam int c_nb = 8;
  localparam int c_dw = 32;
  localparam int c_pw = 2;
  localparam int c_cw = 4;

  logic              clk;
  logic              reset;
  logic              mon_en;
  logic              clr_cnt;
  logic [c_nb-1:0]      ctag;
  logic [c_nb*c_dw-1:0] data;
  logic [c_nb*c_pw-1:0] par;
  logic [c_nb-1:0]      ue;
  logic [c_nb-1:0]      pkt_done;
  logic [c_nb-1:0]      err_vec;
  logic                 err_vld;
  logic [2:0]           err_bank;
  logic [1:0]           err_code;
  logic [c_nb-1:0]      err_sticky;
  logic [c_nb*c_cw-1:0] ue_cnt;
  logic [c_nb*c_cw-1:0] pkt_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int err_events;
  int done_cnt [c_nb];

  l2_sio_resp_chk #(
    .NUM_BANKS (c_nb),
    .DATA_W    (c_dw),
    .PAR_W     (c_pw),
    .PKT_BEATS (16),
    .CNT_W     (c_cw)
  ) dut (
    .iol2clk          (clk),
    .reset            (reset),
    .mon_en           (mon_en),
    .clr_cnt          (clr_cnt),
    .l2b_sio_ctag_vld (ctag),
    .l2b_sio_data     (data),
    .l2b_sio_parity   (par),
    .l2b_sio_ue_err   (ue),
    .pkt_done         (pkt_done),
    .err_vec          (err_vec),
    .err_vld          (err_vld),
    .err_bank         (err_bank),
    .err_code         (err_code),
    .err_sticky       (err_sticky),
    .ue_cnt           (ue_cnt),
    .pkt_cnt          (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] good_par(input logic [31:0] d);
    return {^d[31:16], ^d[15:0]};
  endfunction

  // Advance one clock and sample #1 after the edge; track pulses and errors.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int b = 0; b < c_nb; b++) done_cnt[b] += int'(pkt_done[b]);
    if (err_vld) err_events++;
  endtask

  task automatic mon_clr();
    err_events = 0;
    for (int b = 0; b < c_nb; b++) done_cnt[b] = 0;
  endtask

  task automatic clr_in();
    ctag = '0; data = '0; par = '0; ue = '0; clr_cnt = 1'b0;
  endtask

  // Drive one beat on every bank in mask m, clock it, then return to idle.
  task automatic beat_mask(input logic [c_nb-1:0] m, input logic c, input logic u, input logic bad);
    logic [31:0] d;
    logic [1:0]  p;
    d = bad ? 32'h0000_0001 : (32'h3C5A_0000 ^ 32'(cyc * 65539));
    p = bad ? 2'b00 : good_par(d);
    for (int b = 0; b < c_nb; b++) begin
      if (m[b]) begin
        ctag[b] = c;
        data[b*c_dw +: c_dw] = d;
        par[b*c_pw +: c_pw] = p;
        ue[b] = u;
      end
    end
    step();
    clr_in();
  endtask

  task automatic beat(input int b, input logic c, input logic u, input logic bad);
    beat_mask(c_nb'(1) << b, c, u, bad);
  endtask

  task automatic pkt(input int b);
    beat(b, 1'b1, 1'b0, 1'b0);
    repeat (16) beat(b, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pkt_done"}, 64'(pkt_done), 64'h0);
    check({tag, "_err_vec"}, 64'(err_vec), 64'h0);
    check({tag, "_err_vld"}, 64'(err_vld), 64'h0);
    check({tag, "_err_bank"}, 64'(err_bank), 64'h0);
    check({tag, "_err_code"}, 64'(err_code), 64'h0);
    check({tag, "_err_sticky"}, 64'(err_sticky), 64'h0);
    check({tag, "_ue_cnt"}, 64'(ue_cnt), 64'h0);
    check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'h0);
  endtask

  initial begin
    reset = 1'b1; mon_en = 1'b0; clr_in(); mon_clr();
    repeat (2) step();
    check_all_zero("reset");
    reset = 1'b0; mon_en = 1'b1;
    step();

    // Clean packet on bank 3.
    mon_clr();
    beat(3, 1'b1, 1'b0, 1'b0);
    repeat (15) beat(3, 1'b0, 1'b0, 1'b0);
    check("t1_no_early_done", 64'(done_cnt[3]), 64'd0);
    beat(3, 1'b0, 1'b0, 1'b0);
    check("t1_done_after_beat16", 64'(pkt_done), 64'h08);
    step();
    check("t1_done_one_cycle", 64'(pkt_done), 64'h00);
    check("t1_pkt_cnt3", 64'(pkt_cnt[3*c_cw +: c_cw]), 64'd1);
    check("t1_no_err", 64'(err_events), 64'd0);

    // Parity error on beat 5 of bank 0; packet still completes.
    mon_clr();
    beat(0, 1'b1, 1'b0, 1'b0);
    repeat (4) beat(0, 1'b0, 1'b0, 1'b0);
    beat(0, 1'b0, 1'b0, 1'b1);
    check("t2_err_vld", 64'(err_vld), 64'd1);
    check("t2_err_bank", 64'(err_bank), 64'd0);
    check("t2_err_code", 64'(err_code), 64'd0);
    check("t2_sticky", 64'(err_sticky), 64'h01);
    repeat (10) beat(0, 1'b0, 1'b0, 1'b0);
    beat(0, 1'b0, 1'b0, 1'b0);
    check("t2_done", 64'(pkt_done), 64'h01);
    step();
    check("t2_pkt_cnt0", 64'(pkt_cnt[0 +: c_cw]), 64'd1);
    check("t2_one_err_event", 64'(err_events), 64'd1);

    // Overlapping header on beat 7 of bank 5.
    mon_clr();
    beat(5, 1'b1, 1'b0, 1'b0);
    repeat (6) beat(5, 1'b0, 1'b0, 1'b0);
    beat(5, 1'b1, 1'b0, 1'b0);
    check("t3_err_bank", 64'(err_bank), 64'd5);
    check("t3_err_code", 64'(err_code), 64'd2);
    check("t3_no_done", 64'(pkt_done), 64'h00);
    repeat (15) beat(5, 1'b0, 1'b0, 1'b0);
    check("t3_no_done_old_pkt", 64'(done_cnt[5]), 64'd0);
    beat(5, 1'b0, 1'b0, 1'b0);
    check("t3_done_17_after_hdr", 64'(pkt_done), 64'h20);
    step();
    check("t3_pkt_cnt5", 64'(pkt_cnt[5*c_cw +: c_cw]), 64'd1);

    // Simultaneous UE on banks 2 and 6.
    mon_clr();
    beat_mask(8'h44, 1'b1, 1'b0, 1'b0);
    repeat (2) beat_mask(8'h44, 1'b0, 1'b0, 1'b0);
    beat_mask(8'h44, 1'b0, 1'b1, 1'b0);
    check("t4_err_vec", 64'(err_vec), 64'h44);
    check("t4_err_bank", 64'(err_bank), 64'd2);
    check("t4_err_code", 64'(err_code), 64'd1);
    check("t4_ue_cnt2", 64'(ue_cnt[2*c_cw +: c_cw]), 64'd1);
    check("t4_ue_cnt6", 64'(ue_cnt[6*c_cw +: c_cw]), 64'd1);
    repeat (13) beat_mask(8'h44, 1'b0, 1'b0, 1'b0);
    check("t4_done", 64'(pkt_done), 64'h44);
    step();

    // Stray UE on bank 1, then clear coinciding with a UE in DATA.
    mon_clr();
    beat(1, 1'b0, 1'b1, 1'b0);
    check("t5_err_bank", 64'(err_bank), 64'd1);
    check("t5_err_code", 64'(err_code), 64'd3);
    check("t5_ue_cnt1_zero", 64'(ue_cnt[1*c_cw +: c_cw]), 64'd0);
    check("t5_sticky1", 64'(err_sticky[1]), 64'd1);
    beat(1, 1'b1, 1'b0, 1'b0);
    beat(1, 1'b0, 1'b0, 1'b0);
    clr_cnt = 1'b1;
    beat(1, 1'b0, 1'b1, 1'b0);
    check("t5_clr_ue_cnt1", 64'(ue_cnt[1*c_cw +: c_cw]), 64'd1);
    check("t5_clr_sticky", 64'(err_sticky), 64'h02);
    check("t5_clr_ue_cnt2", 64'(ue_cnt[2*c_cw +: c_cw]), 64'd0);
    check("t5_clr_pkt_cnt3", 64'(pkt_cnt[3*c_cw +: c_cw]), 64'd0);
    repeat (14) beat(1, 1'b0, 1'b0, 1'b0);
    check("t5_done", 64'(pkt_done), 64'h02);
    step();
    check("t5_pkt_cnt1", 64'(pkt_cnt[1*c_cw +: c_cw]), 64'd1);

    // Header on the final data beat of bank 7 is an overlap.
    mon_clr();
    beat(7, 1'b1, 1'b0, 1'b0);
    repeat (15) beat(7, 1'b0, 1'b0, 1'b0);
    beat(7, 1'b1, 1'b0, 1'b0);
    check("t7_err_code", 64'(err_code), 64'd2);
    check("t7_err_bank", 64'(err_bank), 64'd7);
    check("t7_no_done", 64'(pkt_done), 64'h00);
    repeat (16) beat(7, 1'b0, 1'b0, 1'b0);
    check("t7_done", 64'(pkt_done), 64'h80);
    step();
    check("t7_pkt_cnt7", 64'(pkt_cnt[7*c_cw +: c_cw]), 64'd1);

    // Saturation on bank 4, then disable mid-packet, then reset mid-packet.
    mon_clr();
    repeat (17) pkt(4);
    step();
    check("t6_pkt_cnt4_sat", 64'(pkt_cnt[4*c_cw +: c_cw]), 64'd15);
    check("t6_done_pulses", 64'(done_cnt[4]), 64'd17);
    mon_clr();
    beat(4, 1'b1, 1'b0, 1'b0);
    repeat (5) beat(4, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b0;
    beat(4, 1'b0, 1'b1, 1'b0);
    repeat (3) beat(4, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    repeat (7) beat(4, 1'b0, 1'b0, 1'b0);
    step();
    check("t6_dis_no_done", 64'(done_cnt[4]), 64'd0);
    check("t6_dis_no_err", 64'(err_events), 64'd0);
    check("t6_dis_pkt_cnt_hold", 64'(pkt_cnt[4*c_cw +: c_cw]), 64'd15);
    check("t6_dis_ue_cnt", 64'(ue_cnt[4*c_cw +: c_cw]), 64'd0);
    beat(4, 1'b1, 1'b0, 1'b0);
    repeat (5) beat(4, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    beat(4, 1'b0, 1'b0, 1'b0);
    check_all_zero("t6_reset");
    reset = 1'b0;
    mon_clr();
    repeat (16) beat(4, 1'b0, 1'b0, 1'b0);
    step();
    check("t6_rst_no_done", 64'(done_cnt[4]), 64'd0);
    check("t6_rst_no_err", 64'(err_events), 64'd0);
    check("t6_rst_pkt_cnt", 64'(pkt_cnt[4*c_cw +: c_cw]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
